// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller.
// Holds the access-size encodings, the controller state enum and the
// offsets of the registers inside the 16-byte MMIO window.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] TOHOST_OFS = 4'h0;
  localparam logic [3:0] CYCLE_OFS  = 4'h4;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU-side request/response bundle of the data memory controller.
// master : CPU (drives req_*, samples rsp_* and tohost_*)
// slave  : controller
interface data_mem_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] tohost_o;
  logic        tohost_valid_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, tohost_o, tohost_valid_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, tohost_o, tohost_valid_o
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for loads and stores.
// addr_lo/size/is_unsigned : low address bits, access size, load zero-extend
// st_data  : right-aligned store data      -> wr_data/wr_strb : lane-replicated data + lane enables
// rd_word  : addressed 32-bit word          -> ld_data        : selected and extended load value
// misalign : half/word access not naturally aligned
module lsu_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wr_data  = st_data;
    wr_strb  = 4'b0000;
    ld_data  = rd_word;
    misalign = 1'b0;
    ld_byte  = rd_word[7:0];
    ld_half  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    case (addr_lo)
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      2'd3:    ld_byte = rd_word[31:24];
      default: ld_byte = rd_word[7:0];
    endcase

    case (size)
      SZ_BYTE: begin
        wr_data = {4{st_data[7:0]}};
        wr_strb = 4'b0001 << addr_lo;
        ld_data = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        wr_data  = {2{st_data[15:0]}};
        wr_strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
        ld_data  = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        misalign = (addr_lo != 2'b00);
        wr_strb  = 4'b1111;
      end
      default: wr_strb = 4'b0000;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data memory controller: word RAM plus a small MMIO
// window (tohost register, free-running cycle counter).
// clk, reset_n_i : clock, async active-low reset
// bus            : request/response bundle (slave side)
//
// state | meaning
// IDLE  | ready; request fields captured on acceptance
// WAIT  | wait-state timer counting down to zero
// RESP  | one-cycle response strobe; stores committed on entry
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          RAM_DEPTH   = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           reset_n_i,
  data_mem_ctrl_if.slave bus
);

  localparam int          IDX_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_DEPTH) * 33'd4;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        enter_resp;

  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;

  logic        cur_we, cur_uns;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;

  logic [31:0] ram [RAM_DEPTH];
  logic [31:0] cycle_cnt_q, tohost_q;
  logic        tohost_pls_q;

  logic [IDX_W-1:0] ram_idx;
  logic        is_ram, sel_mmio, fault, ram_we, tohost_wr;
  logic [3:0]  mmio_ofs;
  logic [31:0] rd_word, wr_data, ld_data;
  logic [3:0]  wr_strb;
  logic        misalign;

  // With zero wait states the store commits on the acceptance edge itself,
  // so the live bus fields are used while IDLE and the captured ones after.
  assign cur_we    = (state_q == IDLE) ? bus.req_we_i       : we_q;
  assign cur_uns   = (state_q == IDLE) ? bus.req_unsigned_i : uns_q;
  assign cur_addr  = (state_q == IDLE) ? bus.req_addr_i     : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.req_wdata_i    : wdata_q;
  assign cur_size  = (state_q == IDLE) ? bus.req_size_i     : size_q;

  assign ram_idx  = cur_addr[IDX_W+1:2];
  assign is_ram   = ({1'b0, cur_addr} < RAM_BYTES);
  assign sel_mmio = !is_ram && (cur_addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_ofs = cur_addr[3:0];

  always_comb begin
    fault = 1'b0;
    if (cur_size == SZ_ILL || misalign) begin
      fault = 1'b1;
    end else if (sel_mmio) begin
      if (cur_size != SZ_WORD) begin
        fault = 1'b1;
      end else begin
        case (mmio_ofs)
          TOHOST_OFS: fault = 1'b0;
          CYCLE_OFS:  fault = cur_we;
          default:    fault = 1'b1;
        endcase
      end
    end else if (!is_ram) begin
      fault = 1'b1;
    end
  end

  always_comb begin
    rd_word = tohost_q;
    if (is_ram)                       rd_word = ram[ram_idx];
    else if (mmio_ofs == CYCLE_OFS)   rd_word = cycle_cnt_q;
  end

  lsu_lane_align u_lane (
    .addr_lo     (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .st_data     (cur_wdata),
    .rd_word     (rd_word),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .ld_data     (ld_data),
    .misalign    (misalign)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (WAIT_STATES > 0) begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // reset_n_i gating keeps a request presented during reset from writing RAM.
  assign ram_we    = reset_n_i && enter_resp && cur_we && is_ram && !fault;
  assign tohost_wr = enter_resp && cur_we && sel_mmio && !fault && (mmio_ofs == TOHOST_OFS);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 3'd0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      size_q       <= 2'b00;
      cycle_cnt_q  <= 32'h0;
      tohost_q     <= 32'h0;
      tohost_pls_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cycle_cnt_q  <= cycle_cnt_q + 32'd1;
      tohost_pls_q <= tohost_wr;
      if (tohost_wr) tohost_q <= cur_wdata;
      if (state_q == IDLE && bus.req_valid_i) begin
        we_q    <= bus.req_we_i;
        uns_q   <= bus.req_unsigned_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        size_q  <= bus.req_size_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) ram[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign bus.req_ready_o    = (state_q == IDLE);
  assign bus.rsp_valid_o    = (state_q == RESP);
  assign bus.rsp_err_o      = (state_q == RESP) && fault;
  assign bus.rsp_rdata_o    = ((state_q == RESP) && !fault && !cur_we) ? ld_data : 32'h0;
  assign bus.tohost_o       = tohost_q;
  assign bus.tohost_valid_o = tohost_pls_q;

endmodule
